// File: rtl/csa_pkg.sv
// Shared constants and FSM state type for the carry-save-adder arbiter slice.
// The operand packing and result width are fixed by the 4-input adder.
package csa_pkg;
  localparam int OPW  = 4;
  localparam int SUMW = OPW + 2;
  localparam int NOPS = 4;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    RESP
  } state_t;
endpackage

// File: rtl/carry_save_adder.sv
// Four-operand adder: two carry-save compression rows reduce a,b,c,d to a
// sum/carry pair, then a single carry-propagate add produces {cout,sum}.
module carry_save_adder
  import csa_pkg::*;
#(
  parameter int W  = OPW,
  parameter int SW = SUMW
) (
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic [W-1:0]  c,
  input  logic [W-1:0]  d,
  output logic [SW-2:0] sum,
  output logic          cout
);
  logic [SW-1:0] ax, bx, cx, dx;
  logic [SW-1:0] s1, c1, s2, c2, total;

  assign ax = {{(SW-W){1'b0}}, a};
  assign bx = {{(SW-W){1'b0}}, b};
  assign cx = {{(SW-W){1'b0}}, c};
  assign dx = {{(SW-W){1'b0}}, d};

  // Operands are zero-extended by two bits, so the shifted carries never overflow.
  assign s1 = ax ^ bx ^ cx;
  assign c1 = ((ax & bx) | (ax & cx) | (bx & cx)) << 1;
  assign s2 = s1 ^ c1 ^ dx;
  assign c2 = ((s1 & c1) | (s1 & dx) | (c1 & dx)) << 1;

  assign total       = s2 + c2;
  assign {cout, sum} = total;
endmodule

// File: rtl/csa_share_arbiter.sv
// Two requesters share one carry-save adder; round-robin grant in IDLE,
// one cycle of calculation, then the result is held until consumed.
module csa_share_arbiter #(
  parameter int OPW  = csa_pkg::OPW,
  parameter int SUMW = csa_pkg::SUMW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [4*OPW-1:0]  req_ops0,
  input  logic [4*OPW-1:0]  req_ops1,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [SUMW-1:0]   rsp_sum,
  output logic              busy
);
  import csa_pkg::*;

  state_t             state;
  logic               prio;
  logic               id;
  logic [4*OPW-1:0]   ops;
  logic [1:0]         grant;
  logic [SUMW-2:0]    csa_sum;
  logic               csa_cout;

  always_comb begin
    grant = 2'b00;
    if (!prio) begin
      if (req_valid[0])      grant = 2'b01;
      else if (req_valid[1]) grant = 2'b10;
    end else begin
      if (req_valid[1])      grant = 2'b10;
      else if (req_valid[0]) grant = 2'b01;
    end
  end

  // Gated by rst_n so the strobe is low during reset even though state is IDLE.
  assign req_ready = (state == IDLE && rst_n) ? grant : 2'b00;
  assign busy      = (state != IDLE);

  carry_save_adder #(.W(OPW), .SW(SUMW)) u_csa (
    .a    (ops[OPW-1:0]),
    .b    (ops[2*OPW-1:OPW]),
    .c    (ops[3*OPW-1:2*OPW]),
    .d    (ops[4*OPW-1:3*OPW]),
    .sum  (csa_sum),
    .cout (csa_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      prio      <= 1'b0;
      id        <= 1'b0;
      ops       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_sum   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_ready) begin
            ops   <= req_ready[1] ? req_ops1 : req_ops0;
            id    <= req_ready[1];
            prio  <= ~req_ready[1];
            state <= CALC;
          end
        end
        CALC: begin
          rsp_sum   <= {csa_cout, csa_sum};
          rsp_id    <= id;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_csa_share_arbiter.sv
// Directed bench for csa_share_arbiter: a vector table of transactions with
// hand-computed sums and grants, plus reset and idle corner sequences.
module tb_csa_share_arbiter;
  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req_ops0;
  logic [15:0] req_ops1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [5:0]  rsp_sum;
  logic        busy;

  int total;
  int bad;

  typedef struct {
    logic [1:0]  valid;
    logic [15:0] ops0;
    logic [15:0] ops1;
    logic        id;
    logic [5:0]  sum;
    int          hold;
  } vec_t;

  vec_t vecs[9];

  csa_share_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_ops0  (req_ops0),
    .req_ops1  (req_ops1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge with the DUT in IDLE; returns at a negedge back in IDLE.
  task automatic apply_stimulus(input logic [1:0] valid, input logic [15:0] ops0,
                                input logic [15:0] ops1, input logic exp_id,
                                input logic [5:0] exp_sum, input int hold);
    req_valid = valid;
    req_ops0  = ops0;
    req_ops1  = ops1;
    rsp_ready = 1'b0;
    #1;
    check_output("grant", {14'd0, req_ready}, exp_id ? 16'h2 : 16'h1);
    check_output("idle_busy", {15'd0, busy}, 16'h0);
    @(posedge clk);
    @(negedge clk);
    req_ops0 = ~ops0;
    req_ops1 = ~ops1;
    check_output("calc_busy", {15'd0, busy}, 16'h1);
    check_output("calc_rsp_valid", {15'd0, rsp_valid}, 16'h0);
    check_output("calc_req_ready", {14'd0, req_ready}, 16'h0);
    @(negedge clk);
    for (int i = 0; i < hold; i++) begin
      check_output("hold_rsp_valid", {15'd0, rsp_valid}, 16'h1);
      check_output("hold_rsp_sum", {10'd0, rsp_sum}, {10'd0, exp_sum});
      check_output("hold_rsp_id", {15'd0, rsp_id}, {15'd0, exp_id});
      check_output("hold_req_ready", {14'd0, req_ready}, 16'h0);
      @(negedge clk);
    end
    check_output("rsp_valid", {15'd0, rsp_valid}, 16'h1);
    check_output("rsp_sum", {10'd0, rsp_sum}, {10'd0, exp_sum});
    check_output("rsp_id", {15'd0, rsp_id}, {15'd0, exp_id});
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check_output("done_rsp_valid", {15'd0, rsp_valid}, 16'h0);
    check_output("done_busy", {15'd0, busy}, 16'h0);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    req_valid = 2'b00;
    req_ops0  = 16'h0;
    req_ops1  = 16'h0;
    rsp_ready = 1'b0;

    // Grant sequence assumes prio=0 after reset and prio=~winner after each grant.
    vecs[0] = '{2'b01, 16'hFFFF, 16'h0000, 1'b0, 6'd60, 0};
    vecs[1] = '{2'b10, 16'hFFFF, 16'h0000, 1'b1, 6'd0,  0};
    vecs[2] = '{2'b11, 16'h4321, 16'h5555, 1'b0, 6'd10, 0};
    vecs[3] = '{2'b11, 16'h4321, 16'h5555, 1'b1, 6'd20, 0};
    vecs[4] = '{2'b11, 16'h4321, 16'h5555, 1'b0, 6'd10, 0};
    vecs[5] = '{2'b11, 16'h4321, 16'h5555, 1'b1, 6'd20, 0};
    vecs[6] = '{2'b01, 16'h9A7C, 16'h5555, 1'b0, 6'd38, 5};
    vecs[7] = '{2'b01, 16'h1234, 16'h5555, 1'b0, 6'd10, 0};
    vecs[8] = '{2'b11, 16'h1234, 16'h8421, 1'b1, 6'd15, 0};

    #12;
    check_output("reset_rsp_valid", {15'd0, rsp_valid}, 16'h0);
    check_output("reset_busy", {15'd0, busy}, 16'h0);
    check_output("reset_rsp_sum", {10'd0, rsp_sum}, 16'h0);
    check_output("reset_rsp_id", {15'd0, rsp_id}, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 9; v++)
      apply_stimulus(vecs[v].valid, vecs[v].ops0, vecs[v].ops1,
                     vecs[v].id, vecs[v].sum, vecs[v].hold);

    // No requests: stays idle and prio (0) is untouched.
    req_valid = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("noreq_busy", {15'd0, busy}, 16'h0);
      check_output("noreq_req_ready", {14'd0, req_ready}, 16'h0);
    end
    apply_stimulus(2'b11, 16'h4321, 16'h5555, 1'b0, 6'd10, 0);

    // Reset asserted mid-CALC after a grant that left prio=1.
    req_valid = 2'b01;
    req_ops0  = 16'h1111;
    @(posedge clk);
    @(negedge clk);
    check_output("pre_reset_busy", {15'd0, busy}, 16'h1);
    #2 rst_n = 1'b0;
    #1;
    check_output("async_rsp_valid", {15'd0, rsp_valid}, 16'h0);
    check_output("async_busy", {15'd0, busy}, 16'h0);
    check_output("async_req_ready", {14'd0, req_ready}, 16'h0);
    check_output("async_rsp_sum", {10'd0, rsp_sum}, 16'h0);
    check_output("async_rsp_id", {15'd0, rsp_id}, 16'h0);
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("post_reset_rsp_valid", {15'd0, rsp_valid}, 16'h0);
      check_output("post_reset_busy", {15'd0, busy}, 16'h0);
    end
    apply_stimulus(2'b11, 16'h4321, 16'h5555, 1'b0, 6'd10, 0);
    apply_stimulus(2'b11, 16'h4321, 16'h5555, 1'b1, 6'd20, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/csa_share_arbiter.md
CSA_SHARE_ARBITER -- requirements
Module: csa_share_arbiter

Interface
REQ-001 SHALL have parameter OPW, default 4: operand width; only 4 is supported, matching the shared 4-operand carry-save adder.
REQ-002 SHALL have parameter SUMW, default 6: result width (OPW+2).
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid, input, 2: per-requester request valid.
REQ-006 SHALL have port req_ready, output, 2: per-requester accept strobe.
REQ-007 SHALL have port req_ops0, input, 16: requester 0 operands {d,c,b,a}, 4 bits each, a in [3:0].
REQ-008 SHALL have port req_ops1, input, 16: requester 1 operands, same packing.
REQ-009 SHALL have port rsp_valid, output, 1: result valid.
REQ-010 SHALL have port rsp_ready, input, 1: consumer accepts result.
REQ-011 SHALL have port rsp_id, output, 1: requester that owns the result.
REQ-012 SHALL have port rsp_sum, output, SUMW: a+b+c+d, zero-extended, unsigned.
REQ-013 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-014 SHALL implement the FSM IDLE -> CALC -> RESP -> IDLE, one state per cycle except RESP, which holds until rsp_ready is high.
REQ-015 SHALL, in IDLE only, drive req_ready one-hot to the granted requester among those with req_valid high; req_ready SHALL be 0 in all other states.
REQ-016 SHALL decide grant combinationally from req_valid and priority pointer prio: prio=0 favours requester 0, prio=1 favours requester 1.
REQ-017 SHALL, on handshake (req_valid[i]&req_ready[i]), capture that requester's 16 operand bits and id i into internal registers, set prio to ~i, and enter CALC.
REQ-018 SHALL, in CALC, apply the captured operands to the shared adder, register {cout,sum} into rsp_sum, and enter RESP.
REQ-019 SHALL hold rsp_valid high throughout RESP, with rsp_sum and rsp_id stable until the rsp_valid&rsp_ready cycle.
REQ-020 SHALL make a result accepted at edge T visible as rsp_valid at edge T+2, giving a minimum of 3 cycles per transaction with no IDLE bypass.
REQ-021 SHALL, on the rsp_valid&rsp_ready cycle, return to IDLE; a new grant is possible on the following cycle.
REQ-022 SHALL ignore a req_valid that drops before the grant (no capture); operand changes after the handshake SHALL NOT affect the result.
REQ-023 SHALL leave prio unchanged when no grant occurs.

Reset
REQ-024 SHALL, while rst_n is low, force the state to IDLE, prio=0, rsp_valid=0, rsp_id=0, rsp_sum=0, busy=0, req_ready=0, and clear the operand registers to 0.
REQ-025 SHALL discard any in-flight transaction when rst_n is asserted in CALC or RESP; no rsp_valid SHALL follow reset release for that transaction.

Structure
REQ-026 SHALL place the state enum (IDLE, CALC, RESP) and the OPW/SUMW constants in the shared package csa_pkg.
REQ-027 SHALL instantiate exactly one carry_save_adder as the shared datapath; this block adds no other arithmetic.

Verification
REQ-028 SHALL cover: req 0 ops a=b=c=d=15 -> rsp_sum=60, rsp_id=0, rsp_valid 2 cycles after accept.
REQ-029 SHALL cover: both requesters valid after reset, ops0 {1,2,3,4}, ops1 {5,5,5,5} -> first grant 0 (sum 10), next grant 1 (sum 20).
REQ-030 SHALL cover: both requesters valid continuously -> grants alternate 0,1,0,1 over 4 transactions.
REQ-031 SHALL cover: rsp_ready low 5 cycles in RESP -> rsp_valid, rsp_sum and rsp_id stable; req_ready stays 0 throughout.
REQ-032 SHALL cover: rst_n pulsed low during CALC -> all outputs 0 asynchronously, no response after release, first post-reset grant to requester 0.
REQ-033 SHALL cover: requester 1 alone with ops {0,0,0,0} -> rsp_sum=0 and rsp_id=1, then prio=0.
